// File: rtl/pwm_pkg.sv
// Shared types for the multi-channel PWM block: alignment mode and counter direction.
package pwm_pkg;

  typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_e;
  typedef enum logic {DIR_UP, DIR_DOWN} pwm_dir_e;

endpackage

// File: rtl/pwm_timebase.sv
// Prescaled up/up-down timebase shared by all PWM channels; flags the period boundary tick.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [WIDTH-1:0]   period,
  input  pwm_mode_e          mode,
  output logic               tick,
  output logic               boundary,
  output logic [WIDTH-1:0]   cnt,
  output pwm_dir_e           dir
);

  logic [PRESC_W-1:0] presc_cnt;
  logic [PRESC_W-1:0] presc_next;
  logic [WIDTH-1:0]   cnt_next;
  pwm_dir_e           dir_next;

  always_comb begin
    tick       = en && (presc_cnt == prescale);
    presc_next = (tick || !en) ? '0 : presc_cnt + 1'b1;
    cnt_next   = cnt;
    dir_next   = dir;
    boundary   = 1'b0;
    if (!en) begin
      cnt_next = '0;
      dir_next = DIR_UP;
    end else if (tick) begin
      if (mode == PWM_EDGE) begin
        if (cnt >= period) boundary = 1'b1;
        else               cnt_next = cnt + 1'b1;
      end else if (dir == DIR_UP) begin
        // Periods of 0 or 1 have no down leg; the top of the ramp ends the period.
        if (cnt >= period) begin
          if (period <= WIDTH'(1)) begin
            boundary = 1'b1;
          end else begin
            cnt_next = period - 1'b1;
            dir_next = DIR_DOWN;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end else begin
        if (cnt <= WIDTH'(1)) boundary = 1'b1;
        else                  cnt_next = cnt - 1'b1;
      end
      if (boundary) begin
        cnt_next = '0;
        dir_next = DIR_UP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt <= '0;
      cnt       <= '0;
      dir       <= DIR_UP;
    end else begin
      presc_cnt <= presc_next;
      cnt       <= cnt_next;
      dir       <= dir_next;
    end
  end

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: double-buffered period/duty/mode, per-channel compare and polarity.
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [PRESC_W-1:0]      prescale,
  input  logic [WIDTH-1:0]        period,
  input  logic [NUM_CH*WIDTH-1:0] duty,
  input  logic                    center,
  input  logic [NUM_CH-1:0]       invert,
  input  logic                    load,
  output logic                    update_pending,
  output logic                    period_end,
  output logic [NUM_CH-1:0]       pwm
);

  logic [WIDTH-1:0]        stg_period, act_period;
  logic [NUM_CH*WIDTH-1:0] stg_duty, act_duty;
  pwm_mode_e               stg_mode, act_mode, in_mode;
  logic                    tick, boundary, apply_now;
  logic [WIDTH-1:0]        cnt;
  pwm_dir_e                dir;
  logic [NUM_CH-1:0]       raw;

  assign in_mode = pwm_mode_e'(center);

  pwm_timebase #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) u_timebase (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .prescale (prescale),
    .period   (act_period),
    .mode     (act_mode),
    .tick     (tick),
    .boundary (boundary),
    .cnt      (cnt),
    .dir      (dir)
  );

  // Active values only change where the counter restarts at 0/up, so no runt pulses.
  assign apply_now = boundary || !en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_period     <= '0;
      stg_duty       <= '0;
      stg_mode       <= PWM_EDGE;
      act_period     <= '0;
      act_duty       <= '0;
      act_mode       <= PWM_EDGE;
      update_pending <= 1'b0;
    end else if (load) begin
      stg_period <= period;
      stg_duty   <= duty;
      stg_mode   <= in_mode;
      if (apply_now) begin
        act_period     <= period;
        act_duty       <= duty;
        act_mode       <= in_mode;
        update_pending <= 1'b0;
      end else begin
        update_pending <= 1'b1;
      end
    end else if (update_pending && apply_now) begin
      act_period     <= stg_period;
      act_duty       <= stg_duty;
      act_mode       <= stg_mode;
      update_pending <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_cmp
    assign raw[i] = cnt < act_duty[i*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_end <= 1'b0;
      pwm        <= '0;
    end else begin
      period_end <= tick && boundary;
      pwm        <= en ? (raw ^ invert) : invert;
    end
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch: per-clk expected {update_pending, period_end, pwm} queue.
module tb_pwm_multi_ch;

  localparam int NUM_CH  = 4;
  localparam int WIDTH   = 8;
  localparam int PRESC_W = 8;
  localparam int W       = NUM_CH + 2;

  logic                    clk;
  logic                    rst;
  logic                    en;
  logic [PRESC_W-1:0]      prescale;
  logic [WIDTH-1:0]        period;
  logic [NUM_CH*WIDTH-1:0] duty;
  logic                    center;
  logic [NUM_CH-1:0]       invert;
  logic                    load;
  logic                    update_pending;
  logic                    period_end;
  logic [NUM_CH-1:0]       pwm;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // Values driven on the mid-window load strobe
  logic [WIDTH-1:0]        n_period;
  logic [NUM_CH*WIDTH-1:0] n_duty;
  logic                    n_center;

  pwm_multi_ch #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .prescale       (prescale),
    .period         (period),
    .duty           (duty),
    .center         (center),
    .invert         (invert),
    .load           (load),
    .update_pending (update_pending),
    .period_end     (period_end),
    .pwm            (pwm)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic logic [NUM_CH-1:0] model_pwm(input logic [WIDTH-1:0] p,
                                                  input logic [NUM_CH*WIDTH-1:0] d,
                                                  input logic ctr, input int t);
    int c;
    int pi;
    logic [NUM_CH-1:0] r;
    pi = int'(p);
    c  = (ctr && t > pi) ? 2 * pi - t : t;
    for (int i = 0; i < NUM_CH; i++) r[i] = (c < int'(d[i*WIDTH +: WIDTH]));
    return r;
  endfunction

  function automatic int period_ticks(input logic [WIDTH-1:0] p, input logic ctr);
    if (!ctr) return int'(p) + 1;
    return (p == 0) ? 1 : 2 * int'(p);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observed();
    return 32'({update_pending, period_end, pwm});
  endfunction

  // ---------------- driver tasks ----------------
  task automatic configure(input logic [WIDTH-1:0] p, input logic [NUM_CH*WIDTH-1:0] d,
                           input logic ctr, input int presc, input logic [NUM_CH-1:0] inv);
    @(negedge clk);
    en       = 1'b0;
    prescale = PRESC_W'(presc);
    invert   = inv;
    period   = p;
    duty     = d;
    center   = ctr;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    en   = 1'b1;
  endtask

  task automatic sync_period(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_end !== 1'b1 && n < 300);
    check(tag, 32'(period_end), 32'd1);
  endtask

  // Expects nper periods starting the clk after a period_end; optional load at index load_j.
  task automatic run_window(input logic [WIDTH-1:0] p, input logic [NUM_CH*WIDTH-1:0] d,
                            input logic ctr, input int presc, input logic [NUM_CH-1:0] inv,
                            input int nper, input int load_j, input string tag);
    int lc;
    logic [NUM_CH-1:0] e_pwm;
    logic e_pe;
    logic e_pend;
    lc = period_ticks(p, ctr) * (presc + 1);
    for (int per = 0; per < nper; per++) begin
      for (int j = 0; j < lc; j++) begin
        e_pwm  = model_pwm(p, d, ctr, j / (presc + 1)) ^ inv;
        e_pe   = (j == lc - 1);
        e_pend = (per == 0) && (load_j >= 0) && (j > load_j) && (j < lc - 1);
        exp_q.push_back({e_pend, e_pe, e_pwm});
      end
    end
    for (int per = 0; per < nper; per++) begin
      for (int j = 0; j < lc; j++) begin
        @(negedge clk);
        load = 1'b0;
        check(tag, observed(), 32'(exp_q.pop_front()));
        if (per == 0 && j == load_j) begin
          period = n_period;
          duty   = n_duty;
          center = n_center;
          load   = 1'b1;
        end
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    prescale = '0;
    period   = '0;
    duty     = '0;
    center   = 1'b0;
    invert   = '0;
    load     = 1'b0;
    n_period = '0;
    n_duty   = '0;
    n_center = 1'b0;

    // reset state
    @(negedge clk);
    exp_q.push_back('0);
    check("reset", observed(), 32'(exp_q.pop_front()));
    @(negedge clk);
    rst = 1'b0;

    // edge, P=9, prescale 0
    configure(8'd9, {8'd5, 8'd10, 8'd0, 8'd3}, 1'b0, 0, 4'b0000);
    sync_period("edge_sync");
    run_window(8'd9, {8'd5, 8'd10, 8'd0, 8'd3}, 1'b0, 0, 4'b0000, 2, -1, "edge_p9");

    // mid-period load P=9->19, D0=3->15: old period completes untouched
    n_period = 8'd19;
    n_duty   = {8'd20, 8'd1, 8'd19, 8'd15};
    n_center = 1'b0;
    run_window(8'd9, {8'd5, 8'd10, 8'd0, 8'd3}, 1'b0, 0, 4'b0000, 1, 4, "mid_load_old");
    run_window(8'd19, {8'd20, 8'd1, 8'd19, 8'd15}, 1'b0, 0, 4'b0000, 2, -1, "mid_load_new");

    // center, P=4, prescale 1
    configure(8'd4, {8'd5, 8'd4, 8'd0, 8'd2}, 1'b1, 1, 4'b0000);
    sync_period("center_sync");
    run_window(8'd4, {8'd5, 8'd4, 8'd0, 8'd2}, 1'b1, 1, 4'b0000, 2, -1, "center_p4");

    // duty extremes with inverted polarity on one channel
    configure(8'd9, {8'd255, 8'd9, 8'd10, 8'd0}, 1'b0, 0, 4'b0100);
    sync_period("extreme_sync");
    run_window(8'd9, {8'd255, 8'd9, 8'd10, 8'd0}, 1'b0, 0, 4'b0100, 2, -1, "duty_extremes");

    // P=0 edge: boundary on every tick
    configure(8'd0, {8'd0, 8'd2, 8'd1, 8'd0}, 1'b0, 0, 4'b0000);
    sync_period("p0_sync");
    run_window(8'd0, {8'd0, 8'd2, 8'd1, 8'd0}, 1'b0, 0, 4'b0000, 4, -1, "p0_edge");

    // disabled output follows polarity
    @(negedge clk);
    en     = 1'b0;
    invert = 4'b0010;
    @(negedge clk);
    exp_q.push_back({1'b0, 1'b0, 4'b0010});
    check("en0_invert", observed(), 32'(exp_q.pop_front()));

    // load on the exact boundary clk, switching to center mode
    configure(8'd9, {8'd0, 8'd0, 8'd6, 8'd3}, 1'b0, 0, 4'b0000);
    sync_period("bnd_sync");
    n_period = 8'd5;
    n_duty   = {8'd9, 8'd5, 8'd1, 8'd3};
    n_center = 1'b1;
    run_window(8'd9, {8'd0, 8'd0, 8'd6, 8'd3}, 1'b0, 0, 4'b0000, 1, 8, "bnd_load_old");
    run_window(8'd5, {8'd9, 8'd5, 8'd1, 8'd3}, 1'b1, 0, 4'b0000, 2, -1, "bnd_load_new");

    // asynchronous reset mid-period with a pending load
    configure(8'd9, {8'd8, 8'd8, 8'd8, 8'd8}, 1'b0, 0, 4'b0000);
    sync_period("rst_sync");
    repeat (3) @(negedge clk);
    period = 8'd19;
    duty   = {8'd12, 8'd12, 8'd12, 8'd12};
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    exp_q.push_back({1'b1, 1'b0, 4'b1111});
    check("rst_pre", observed(), 32'(exp_q.pop_front()));
    #2;
    rst = 1'b1;
    #1;
    exp_q.push_back('0);
    check("rst_async", observed(), 32'(exp_q.pop_front()));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sync_period("post_rst_sync");
    run_window(8'd0, '0, 1'b0, 0, 4'b0000, 4, -1, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
